// File: rtl/sp_pkg.sv
// -----------------------------------------------------------------------------
// sp_pkg
// Definitions shared by the SP core and its issue controller:
//   IW / DW       instruction and result widths
//   state_t, ST_* issue-controller FSM encoding
//   ERR_*         bit positions inside the controller's err[1:0] output
// -----------------------------------------------------------------------------
package sp_pkg;

    localparam int IW = 14;
    localparam int DW = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_UNEXP   = 1;

endpackage

// File: rtl/sp_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// sp_issue_ctrl_if
// Instruction/result bus between an SP initiator and the SP core.
//   in_valid, instruction : initiator -> SP
//   busy, out_valid, out  : SP -> initiator
// modport master : the initiator (sp_issue_ctrl)
// modport slave  : the SP core
// -----------------------------------------------------------------------------
interface sp_issue_ctrl_if;

    logic                   in_valid;
    logic [sp_pkg::IW-1:0]  instruction;
    logic                   busy;
    logic                   out_valid;
    logic [sp_pkg::DW-1:0]  out;

    modport master (
        output in_valid,
        output instruction,
        input  busy,
        input  out_valid,
        input  out
    );

    modport slave (
        input  in_valid,
        input  instruction,
        output busy,
        output out_valid,
        output out
    );

endinterface

// File: rtl/sp_prog_fifo.sv
// -----------------------------------------------------------------------------
// sp_prog_fifo
// Synchronous DEPTH x W program FIFO with first-word-fall-through head.
// Ports:
//   clk, rst       clock, synchronous active-low reset (pointers/count only)
//   push/push_data write a word; ignored when full
//   pop            discard head; ignored when empty
//   head           word at the read pointer (valid when !empty)
//   full/empty     status flags
//   count          number of stored words (0..DEPTH)
// -----------------------------------------------------------------------------
module sp_prog_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests against the flags and compute next pointers/count.
    always_comb begin
        do_push_s = push && (count_q != CNT_FULL);
        do_pop_s  = pop  && (count_q != '0);

        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/sp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// sp_issue_ctrl
// Initiator for the SP instruction port. A host loads a program into the
// internal queue, pulses start, and the block issues the words to SP
// (respecting busy, with at least one idle cycle between issues), collects
// SP results with an ordinal tag, and flags completion/timeout/extra results.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   prog_valid/instr/ready   host program load handshake (IDLE/DONE only)
//   start, exp_cnt           begin a run; exp_cnt latched at start
//   sp (master modport)      in_valid/instruction out, busy/out_valid/out in
//   res_valid/data/idx       one-cycle strobe per captured SP result
//   done                     level, run finished
//   err                      [0] timeout, [1] unexpected result; sticky
// -----------------------------------------------------------------------------
module sp_issue_ctrl
    import sp_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_valid,
    input  logic [IW-1:0]         prog_instr,
    output logic                  prog_ready,
    input  logic                  start,
    input  logic [7:0]            exp_cnt,
    sp_issue_ctrl_if.master       sp,
    output logic                  res_valid,
    output logic [DW-1:0]         res_data,
    output logic [7:0]            res_idx,
    output logic                  done,
    output logic [1:0]            err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FIFO_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [TW-1:0] IDLE_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            gap_q, gap_d;
    logic [7:0]      exp_q, exp_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic            in_valid_q, in_valid_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic            res_valid_q, res_valid_d;
    logic [DW-1:0]   res_data_q, res_data_d;
    logic [7:0]      res_idx_q, res_idx_d;
    logic            done_q, done_d;
    logic [1:0]      err_q, err_d;

    logic            push_s;
    logic            pop_s;
    logic            prog_ready_s;
    logic [IW-1:0]   fifo_head_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [AW:0]     fifo_count_s;

    sp_prog_fifo #(
        .DEPTH (DEPTH),
        .W     (IW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (prog_instr),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Loading is allowed whenever no run is in progress.
    always_comb begin
        prog_ready_s = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !fifo_full_s;
        push_s       = prog_valid && prog_ready_s;
    end

    // Next-state logic: FSM, issue pacing, result capture and timeout.
    always_comb begin
        state_d     = state_q;
        gap_d       = 1'b0;
        exp_d       = exp_q;
        cnt_d       = cnt_q;
        idle_d      = '0;
        in_valid_d  = 1'b0;
        instr_d     = '0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        done_d      = done_q;
        err_d       = err_q;
        pop_s       = 1'b0;

        // Results are captured in every state but IDLE, including ISSUE.
        if ((state_q != ST_IDLE) && sp.out_valid) begin
            res_valid_d = 1'b1;
            res_data_d  = sp.out;
            res_idx_d   = cnt_q;
            cnt_d       = cnt_q + 8'd1;
            if (cnt_q == exp_q) begin
                err_d[ERR_UNEXP] = 1'b1;
            end else begin
                err_d[ERR_UNEXP] = err_q[ERR_UNEXP];
            end
        end else begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    exp_d  = exp_cnt;
                    cnt_d  = 8'd0;
                    err_d  = 2'b00;
                    done_d = 1'b0;
                    if (!fifo_empty_s) begin
                        state_d = ST_ISSUE;
                    end else if (exp_cnt == 8'd0) begin
                        // Nothing to issue and nothing to wait for.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_ISSUE: begin
                // gap forces an idle cycle after each issue so SP can
                // raise busy before the next busy sample.
                if (!sp.busy && !gap_q && !fifo_empty_s) begin
                    in_valid_d = 1'b1;
                    instr_d    = fifo_head_s;
                    pop_s      = 1'b1;
                    gap_d      = 1'b1;
                    if (fifo_count_s == FIFO_ONE) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    gap_d = 1'b0;
                    if (fifo_empty_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_DRAIN: begin
                // Completion is checked before expiry so a final result in
                // the expiry cycle wins over the timeout.
                if ((cnt_d == exp_q) || err_d[ERR_UNEXP]) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (!sp.out_valid && (idle_q == IDLE_LAST)) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = ST_DONE;
                    done_d             = 1'b1;
                end else if (sp.out_valid) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + IDLE_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            gap_q       <= 1'b0;
            exp_q       <= 8'd0;
            cnt_q       <= 8'd0;
            idle_q      <= '0;
            in_valid_q  <= 1'b0;
            instr_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= 8'd0;
            done_q      <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            exp_q       <= exp_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            in_valid_q  <= in_valid_d;
            instr_q     <= instr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign sp.in_valid    = in_valid_q;
    assign sp.instruction = instr_q;
    assign prog_ready     = prog_ready_s;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_idx        = res_idx_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_sp_issue_ctrl.sv
`timescale 1ns/1ps
module tb_sp_issue_ctrl;
    import sp_pkg::*;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 1023;

    logic            clk;
    logic            rst;
    logic            prog_valid;
    logic [IW-1:0]   prog_instr;
    logic            prog_ready;
    logic            start;
    logic [7:0]      exp_cnt;
    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic [7:0]      res_idx;
    logic            done;
    logic [1:0]      err;

    sp_issue_ctrl_if sp_bus ();

    sp_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_valid (prog_valid),
        .prog_instr (prog_instr),
        .prog_ready (prog_ready),
        .start      (start),
        .exp_cnt    (exp_cnt),
        .sp         (sp_bus),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_idx    (res_idx),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt    = 0;
    int mis_cnt    = 0;
    int cyc        = 0;
    int last_issue = -100;
    int done_rise  = -1;
    logic done_prev = 1'b0;

    // Reference model: program words awaiting issue, and the result bookkeeping.
    logic [IW-1:0] exp_words[$];
    logic [IW-1:0] load_q[$];
    int            issue_log[$];
    logic          run_active = 1'b0;
    logic [7:0]    m_exp      = 8'd0;
    logic [7:0]    m_cnt      = 8'd0;
    logic          m_err1     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec_cnt++;
        assert (obs === expv) else begin
            mis_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: capture what was driven, step past the edge, check the DUT.
    task automatic tick();
        logic          rst_s, pv_s, st_s, busy_s, ov_s;
        logic [IW-1:0] pi_s;
        logic [7:0]    ec_s;
        logic [DW-1:0] out_s;
        rst_s  = rst;          pv_s = prog_valid;       pi_s  = prog_instr;
        st_s   = start;        ec_s = exp_cnt;          busy_s = sp_bus.busy;
        ov_s   = sp_bus.out_valid;                      out_s = sp_bus.out;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_s) begin
            exp_words.delete();
            run_active = 1'b0;
            m_cnt      = 8'd0;
            m_err1     = 1'b0;
            last_issue = -100;
            chk("rst_in_valid", 32'(sp_bus.in_valid), 32'd0);
            chk("rst_res_valid", 32'(res_valid), 32'd0);
        end else begin
            if (sp_bus.in_valid === 1'b1) begin
                chk("issue_spacing", 32'((cyc - last_issue) >= 2), 32'd1);
                if (exp_words.size() == 0) begin
                    chk("issue_extra", 32'(sp_bus.in_valid), 32'd0);
                end else begin
                    chk("issue_word", 32'(sp_bus.instruction), 32'(exp_words.pop_front()));
                end
                last_issue = cyc;
                issue_log.push_back(cyc);
            end else begin
                chk("idle_instr", 32'(sp_bus.instruction), 32'd0);
            end
            if (busy_s) begin
                chk("busy_hold", 32'(sp_bus.in_valid), 32'd0);
            end
            if (ov_s && run_active) begin
                chk("res_valid", 32'(res_valid), 32'd1);
                chk("res_data", 32'(res_data), 32'(out_s));
                chk("res_idx", 32'(res_idx), 32'(m_cnt));
                if (m_cnt == m_exp) m_err1 = 1'b1;
                m_cnt = m_cnt + 8'd1;
            end else begin
                chk("res_quiet", 32'(res_valid), 32'd0);
            end
            if (pv_s && (exp_words.size() < DEPTH)) begin
                exp_words.push_back(pi_s);
            end
            if (st_s) begin
                run_active = 1'b1;
                m_exp      = ec_s;
                m_cnt      = 8'd0;
                m_err1     = 1'b0;
            end
            chk("err_unexp", 32'(err[ERR_UNEXP]), 32'(m_err1));
        end
        if ((done === 1'b1) && (done_prev !== 1'b1)) done_rise = cyc;
        done_prev = done;
    endtask

    task automatic load_all(input bit gaps);
        foreach (load_q[i]) begin
            if (gaps && ($urandom_range(0, 3) == 0)) tick();
            chk("load_ready", 32'(prog_ready), 32'(exp_words.size() < DEPTH));
            prog_valid = 1'b1;
            prog_instr = load_q[i];
            tick();
        end
        prog_valid = 1'b0;
    endtask

    task automatic start_run(input int e, output int s);
        start   = 1'b1;
        exp_cnt = 8'(e);
        tick();
        start   = 1'b0;
        s       = cyc;
    endtask

    task automatic send_result(input logic [DW-1:0] d);
        sp_bus.out_valid = 1'b1;
        sp_bus.out       = d;
        tick();
        sp_bus.out_valid = 1'b0;
    endtask

    task automatic wait_issues(input int n);
        int k = 0;
        while ((issue_log.size() < n) && (k < 200)) begin
            tick();
            k++;
        end
        if (issue_log.size() < n) chk("issue_wait_expired", 32'(issue_log.size()), 32'(n));
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while ((done !== 1'b1) && (k < budget)) begin
            tick();
            k++;
        end
        if (done !== 1'b1) chk("done_wait_expired", 32'(done), 32'd1);
    endtask

    task automatic rand_run(input int nw, input int e, input int nr);
        int left = nr;
        int k    = 0;
        int s;
        load_q.delete();
        for (int i = 0; i < nw; i++) load_q.push_back(IW'($urandom));
        load_all(1'b1);
        start_run(e, s);
        while ((k < 3000) && !((done === 1'b1) && (left == 0))) begin
            sp_bus.busy = ($urandom_range(0, 3) == 0);
            if ((left > 0) && ($urandom_range(0, 2) == 0)) begin
                sp_bus.out_valid = 1'b1;
                sp_bus.out       = DW'($urandom);
                left--;
            end else begin
                sp_bus.out_valid = 1'b0;
            end
            tick();
            k++;
        end
        sp_bus.busy      = 1'b0;
        sp_bus.out_valid = 1'b0;
        chk("rand_done", 32'(done), 32'd1);
        chk("rand_err", 32'(err), (nr > e) ? 32'd2 : 32'd0);
        chk("rand_all_issued", 32'(exp_words.size()), 32'd0);
        tick();
    endtask

    initial begin
        int s;
        int e;
        int nw;
        int ex;
        int r;
        rst = 1'b0; prog_valid = 1'b0; prog_instr = '0; start = 1'b0; exp_cnt = 8'd0;
        sp_bus.busy = 1'b0; sp_bus.out_valid = 1'b0; sp_bus.out = '0;

        // Reset state.
        tick(); tick();
        rst = 1'b1;
        chk("rst_instruction", 32'(sp_bus.instruction), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_idx", 32'(res_idx), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_prog_ready", 32'(prog_ready), 32'd1);

        // SP result while IDLE must be ignored (monitor expects res_valid=0).
        send_result(8'h55);

        // Three words, busy low: issues at s+1, s+3, s+5 then three results.
        load_q = '{14'h0101, 14'h0202, 14'h0303};
        load_all(1'b0);
        issue_log.delete();
        start_run(3, s);
        chk("run_prog_ready", 32'(prog_ready), 32'd0);
        wait_issues(3);
        for (int i = 0; i < 3; i++) begin
            if (i < issue_log.size()) chk("t1_issue_cycle", 32'(issue_log[i]), 32'(s + 1 + 2 * i));
        end
        tick();
        send_result(8'hA0); tick();
        send_result(8'hA1); tick();
        send_result(8'hA2);
        wait_done(20);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_err", 32'(err), 32'd0);

        // busy held for 10 cycles after the first issue.
        load_q = '{14'h1111, 14'h2222, 14'h3333};
        load_all(1'b0);
        issue_log.delete();
        start_run(0, s);
        wait_issues(1);
        e = cyc;
        sp_bus.busy = 1'b1;
        repeat (10) tick();
        sp_bus.busy = 1'b0;
        wait_issues(2);
        if (issue_log.size() >= 2) chk("busy_second_issue", 32'(issue_log[1]), 32'(e + 11));
        wait_done(50);
        chk("t2_err", 32'(err), 32'd0);

        // Overfill: DEPTH+2 back-to-back pushes, only DEPTH kept.
        load_q.delete();
        for (int i = 0; i < DEPTH + 2; i++) load_q.push_back(IW'(14'h0400 + i));
        load_all(1'b0);
        chk("full_ready", 32'(prog_ready), 32'd0);
        issue_log.delete();
        start_run(0, s);
        wait_done(200);
        chk("full_issue_count", 32'(issue_log.size()), 32'(DEPTH));

        // Timeout: exp_cnt=2, only one result.
        load_q = '{14'h0777};
        load_all(1'b0);
        issue_log.delete();
        start_run(2, s);
        wait_issues(1);
        repeat (3) tick();
        send_result(8'hA5);
        r = cyc;
        done_rise = -1;
        wait_done(TIMEOUT + 50);
        chk("timeout_latency", 32'(done_rise), 32'(r + TIMEOUT));
        chk("timeout_err", 32'(err), 32'd1);

        // Unexpected: exp_cnt=1, two results.
        load_q = '{14'h0888};
        load_all(1'b0);
        issue_log.delete();
        start_run(1, s);
        chk("restart_err_clear", 32'(err), 32'd0);
        wait_issues(1);
        tick();
        send_result(8'hB0);
        wait_done(20);
        tick();
        send_result(8'hB1);
        chk("unexp_idx", 32'(res_idx), 32'd1);
        chk("unexp_err", 32'(err), 32'd2);
        chk("unexp_done", 32'(done), 32'd1);

        // Reset in the middle of ISSUE.
        load_q = '{14'h0A01, 14'h0A02, 14'h0A03, 14'h0A04};
        load_all(1'b0);
        issue_log.delete();
        start_run(0, s);
        wait_issues(1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_ready", 32'(prog_ready), 32'd1);
        repeat (3) tick();

        // Empty queue with exp_cnt=0: done on the cycle after start.
        start_run(0, s);
        chk("empty_start_done", 32'(done), 32'd1);

        // Randomised runs after the reset.
        for (int k = 0; k < 8; k++) begin
            nw = $urandom_range(1, DEPTH);
            ex = $urandom_range(0, 6);
            rand_run(nw, ex, ex + (($urandom_range(0, 2) == 0) ? 1 : 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule

// File: doc/sp_issue_ctrl.md
Name: sp_issue_ctrl

Overview:
- Synthesizable initiator for the SP core's instruction interface. It sits on the opposite end of SP's `in_valid/instruction/busy/out_valid/out` port set.
- A host loads a short program into an internal queue and pulses `start`. The block then issues instructions to SP, honouring `busy`, and collects SP results with index tags.
- It flags completion, timeout, and unexpected results. Used for on-chip self-test and as a bench driver for SP.

Parameters:
- DEPTH, 16, program queue entries (power of 2).
- IW, 14, instruction width.
- DW, 8, result width.
- TIMEOUT, 1023, max idle cycles in DRAIN waiting for a result.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low. 0 = reset on the clock edge.
- prog_valid  in  1  host offers a program word.
- prog_instr  in  IW  program word.
- prog_ready  out  1  queue accepts a word (state IDLE and not full).
- start  in  1  begin issuing; sampled only in IDLE.
- exp_cnt  in  8  number of SP results expected; latched on start.
- in_valid  out  1  instruction valid to SP.
- instruction  out  IW  instruction to SP; 0 when in_valid=0.
- busy  in  1  SP busy; no issue while high.
- out_valid  in  1  SP result valid.
- out  in  DW  SP result.
- res_valid  out  1  one-cycle strobe per captured result.
- res_data  out  DW  captured result.
- res_idx  out  8  0-based result ordinal.
- done  out  1  level; run finished (all exp_cnt results received, or error).
- err  out  2  bit0 = timeout, bit1 = unexpected result (more than exp_cnt). Sticky until next start or reset.

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE; queue empty, pointers 0.
  - in_valid=0, instruction=0, res_valid=0, res_data=0, res_idx=0, done=0, err=0, prog_ready=1.
  - Reset mid-run aborts immediately; no further in_valid.
- Queue: FIFO with DEPTH entries and a count register of width log2(DEPTH)+1.
  - Push when prog_valid & prog_ready.
  - Full implies prog_ready=0; pushes are ignored, not stored.
  - No push outside IDLE.
- States:
  - IDLE: accepts loads. On start=1: latch exp_cnt, clear done, err and the result counter.
    - Queue non-empty: go to ISSUE.
    - Queue empty: go to DRAIN.
    - start with exp_cnt=0 and empty queue: DONE next cycle.
  - ISSUE: each cycle, if busy=0 and gap=0 and queue non-empty:
    - Register in_valid=1 and instruction=head; pop; set gap=1.
    - Otherwise in_valid=0 and instruction=0; gap clears after one idle cycle.
    - Consequence: consecutive issues are at least 2 cycles apart, so SP can raise busy before the next sample.
    - Queue empty after the last pop: go to DRAIN.
  - DRAIN: wait for results.
    - Idle-cycle counter resets on every out_valid.
    - Counter reaching TIMEOUT: set err[0], go to DONE.
    - Result count reaching exp_cnt: go to DONE.
  - DONE: done=1 (level) until start or reset. A start in DONE behaves as in IDLE; the queue is already empty unless reloaded. prog_ready=1 in DONE as well.
- Result capture (any non-IDLE state, including ISSUE):
  - On out_valid=1, next cycle: res_valid=1, res_data=out, res_idx=result count; the count then increments.
  - A result arriving when count==exp_cnt sets err[1]; it is still reported on res_* with its index.
  - res_idx wraps at 255.
  - out_valid while in IDLE is ignored.
- Simultaneous events:
  - out_valid in the same cycle as an issue: both are handled.
  - Final result and timeout expiry in the same cycle: the result wins, no timeout.
- Latency: in_valid appears 1 cycle after the qualifying busy=0 sample. res_valid appears 1 cycle after out_valid.

Decomposition:
- Shared package sp_pkg: IW, DW, state enum {IDLE, ISSUE, DRAIN, DONE}, err bit positions. SP reuses IW and DW from it.
- One natural sub-module: sp_prog_fifo (synchronous FIFO, DEPTH x IW, push/pop/full/empty/count).
- The FSM, timeout counter and result capture stay in sp_issue_ctrl.

Test Plan:
- Load 3 words 14'h0101, 14'h0202, 14'h0303; start with exp_cnt=3; busy held 0.
  → in_valid pulses at cycles s+1, s+3, s+5 carrying those words in order.
  → 3 SP results 8'hA0, 8'hA1, 8'hA2 give res_idx 0/1/2 with matching res_data; done=1; err=0.
- busy=1 for 10 cycles after the first issue.
  → No in_valid during busy; second issue is 1 cycle after busy falls.
- Push DEPTH+2 words.
  → prog_ready=0 after 16 pushes; only the first 16 are issued.
- Start with exp_cnt=2; SP returns only 1 result.
  → After TIMEOUT idle cycles: err=2'b01, done=1.
- Start with exp_cnt=1; SP returns 2 results.
  → Second result shows res_idx=1 and sets err[1].
- Assert rst=0 mid-ISSUE.
  → Next cycle in_valid=0, state IDLE, queue empty, done=0; a later load and start runs cleanly.
